// File: rtl/fip_pkg.sv
// Shared constants and op encoding for the Q16.16 fixed-point arithmetic unit.
package fip_pkg;

    localparam int FIP_WIDTH     = 32;
    localparam int FIP_INT_SHIFT = 16;

    localparam logic [31:0] FIP_ONE = 32'h0001_0000;
    localparam logic [31:0] FIP_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] FIP_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        FIP_ADD  = 2'b00,
        FIP_SUB  = 2'b01,
        FIP_MUL  = 2'b10,
        FIP_RSVD = 2'b11
    } fip_op_e;

endpackage

// File: rtl/fip_32_mul_core.sv
// Combinational signed fixed-point multiply: full product, binary-point shift
// (truncation toward -inf) and overflow detection on the discarded high bits.
module fip_32_mul_core #(
    parameter int WIDTH     = 32,
    parameter int INT_SHIFT = 16
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [2*WIDTH-1:0] hi;

    always_comb begin
        prod     = $signed(x) * $signed(y);
        result   = prod[WIDTH-1+INT_SHIFT:INT_SHIFT];
        // Fits iff every bit from the result sign upward is a sign copy.
        hi       = prod >>> (WIDTH - 1 + INT_SHIFT);
        overflow = (hi != '0) && (hi != '1);
    end

endmodule

// File: rtl/fip_32_alu.sv
// Registered Q16.16 add/sub/mult unit with signed overflow flag, 1-cycle latency.
// Optional saturation on overflow when FIP_SATURATE_EN is defined.
module fip_32_alu
    import fip_pkg::*;
#(
    parameter int WIDTH     = FIP_WIDTH,
    parameter int INT_SHIFT = FIP_INT_SHIFT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] mul_res;
    logic             mul_ovf;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
`ifdef FIP_SATURATE_EN
    logic             sat_neg;
`endif

    fip_32_mul_core #(
        .WIDTH    (WIDTH),
        .INT_SHIFT(INT_SHIFT)
    ) u_mul (
        .x       (x),
        .y       (y),
        .result  (mul_res),
        .overflow(mul_ovf)
    );

    always_comb begin
        sum   = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        diff  = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        res_c = '0;
        ovf_c = 1'b0;
        // With sign-extended operands, overflow shows as the top two bits disagreeing.
        case (fip_op_e'(op))
            FIP_ADD: begin
                res_c = sum[WIDTH-1:0];
                ovf_c = sum[WIDTH] ^ sum[WIDTH-1];
            end
            FIP_SUB: begin
                res_c = diff[WIDTH-1:0];
                ovf_c = diff[WIDTH] ^ diff[WIDTH-1];
            end
            FIP_MUL: begin
                res_c = mul_res;
                ovf_c = mul_ovf;
            end
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
`ifdef FIP_SATURATE_EN
        sat_neg = (fip_op_e'(op) == FIP_MUL) ? (x[WIDTH-1] ^ y[WIDTH-1]) : x[WIDTH-1];
        if (ovf_c) begin
            res_c = sat_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res_c;
                overflow <= ovf_c;
            end
        end
    end

endmodule

// File: tb/tb_fip_32_alu.sv
// Directed self-checking bench for fip_32_alu; expectations follow FIP_SATURATE_EN.
module tb_fip_32_alu;
    import fip_pkg::*;

`ifdef FIP_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic        out_valid;
    logic [31:0] result;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    fip_32_alu #(
        .WIDTH    (32),
        .INT_SHIFT(16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .op       (op),
        .x        (x),
        .y        (y),
        .out_valid(out_valid),
        .result   (result),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one operation at the falling edge; check it after the next rising edge.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic eo);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        x        = a;
        y        = b;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_res"}, result, er);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    endtask

    task automatic bubble(input string tag, input logic [31:0] held_r, input logic held_o);
        @(negedge clk);
        in_valid = 1'b0;
        x        = 32'hDEAD_BEEF;
        y        = 32'h1234_5678;
        @(posedge clk);
        #1;
        check({tag, "_vld"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_res"}, result, held_r);
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, held_o});
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        op       = 2'b00;
        x        = '0;
        y        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_vld", {31'd0, out_valid}, 32'd0);
        check("rst_res", result, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Latency: nothing valid before the first edge after driving
        @(negedge clk);
        in_valid = 1'b1;
        op = 2'b00;
        x = FIP_ONE;
        y = FIP_ONE;
        #1;
        check("lat_pre", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("lat_post", {31'd0, out_valid}, 32'd1);
        check("add_1p1", result, 32'h0002_0000);

        run_op("add_ovf", 2'b00, 32'h7FFF_FFFF, 32'h0001_0000,
               SAT ? 32'h7FFF_FFFF : 32'h8000_FFFF, 1'b1);
        run_op("add_neg", 2'b00, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFE_FFFF, 1'b0);
        run_op("sub_pos", 2'b01, 32'h0002_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op("sub_ovf", 2'b01, 32'h8000_0000, 32'h0000_0001,
               SAT ? 32'h8000_0000 : 32'h7FFF_FFFF, 1'b1);
        run_op("sub_novf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

        run_op("mul_1x1", 2'b10, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op("mul_half", 2'b10, 32'h0000_8000, 32'h0000_8000, 32'h0000_4000, 1'b0);
        run_op("mul_neg", 2'b10, 32'hFFFF_8000, 32'h0000_8000, 32'hFFFF_C000, 1'b0);
        run_op("mul_lsb", 2'b10, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b0);
        run_op("mul_zero", 2'b10, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0);
        run_op("mul_trunc", 2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
        run_op("mul_ovfp", 2'b10, 32'h4000_0000, 32'h0004_0000,
               SAT ? 32'h7FFF_FFFF : 32'h0000_0000, 1'b1);
        run_op("mul_ovfn", 2'b10, 32'hC000_0000, 32'hFFFC_0000,
               SAT ? 32'h7FFF_FFFF : 32'h0000_0000, 1'b1);
        run_op("mul_mixovf", 2'b10, 32'h4000_0000, 32'hFFFC_0000,
               SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1);
        run_op("mul_minmin", 2'b10, 32'h8000_0000, 32'h8000_0000,
               SAT ? 32'h7FFF_FFFF : 32'h0000_0000, 1'b1);

        // Back-to-back mixed ops, then a bubble that must hold the last result
        run_op("b2b_add", 2'b00, 32'h0003_0000, 32'h0000_8000, 32'h0003_8000, 1'b0);
        run_op("b2b_mul", 2'b10, 32'h0002_0000, 32'hFFFF_0000, 32'hFFFE_0000, 1'b0);
        run_op("b2b_sub", 2'b01, 32'h0000_0000, 32'h0001_0000, 32'hFFFF_0000, 1'b0);
        run_op("b2b_ovf", 2'b00, 32'h8000_0000, 32'h8000_0000,
               SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1);
        bubble("bub1", SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1);
        bubble("bub2", SAT ? 32'h8000_0000 : 32'h0000_0000, 1'b1);

        run_op("rsvd", 2'b11, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);
        run_op("novf_clr", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 1'b0);

        // Asynchronous reset between edges while a valid stream is running
        @(negedge clk);
        op = 2'b00;
        x  = 32'h0005_0000;
        y  = 32'h0001_0000;
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("arst_vld", {31'd0, out_valid}, 32'd0);
        check("arst_res", result, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        check("arst_hold_vld", {31'd0, out_valid}, 32'd0);
        check("arst_hold_res", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("post_rst", 2'b01, 32'h0005_0000, 32'h0001_8000, 32'h0003_8000, 1'b0);
        bubble("post_bub", 32'h0003_8000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fip_32_alu.md
Name: fip_32_alu

Overview:
- Registered signed fixed-point arithmetic unit.
- Executes one add, subtract or multiply per cycle on 32-bit Q16.16 operands and flags signed overflow.
- Sits in the ray-tracing datapath wherever a single Q16.16 operation with an overflow indication is needed.
- Supersedes the separate combinational adder, subtractor and multiplier blocks with one op-selected unit.

Parameters:
- WIDTH, 32, operand/result width in bits (two's complement).
- INT_SHIFT, 16, number of fraction bits (binary point position); 1.0 = 1 << INT_SHIFT.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op are valid this cycle.
- op  input  2  00 = add, 01 = sub, 10 = mult, 11 = reserved.
- x  input  WIDTH  signed Q16.16 operand A.
- y  input  WIDTH  signed Q16.16 operand B.
- out_valid  output  1  result and overflow are valid.
- result  output  WIDTH  signed Q16.16 result.
- overflow  output  1  signed overflow of the operation that produced result.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid = 0, result = 0, overflow = 0.
  - Outputs stay in that state while reset is asserted.
  - In-flight operations are discarded.
- Latency: exactly 1 cycle. Inputs sampled at rising clk while in_valid = 1 appear on the next edge with out_valid = 1.
- Throughput: one operation per cycle; no backpressure.
- in_valid = 0: out_valid = 0 next cycle; result and overflow hold their previous values.
- Add:
  - S = x + y computed in WIDTH+1 bits.
  - result = S[WIDTH-1:0], i.e. two's-complement wrap.
  - overflow = 1 iff x and y have equal signs and result sign differs.
- Sub:
  - D = x - y; result = D[WIDTH-1:0].
  - overflow = 1 iff x and y have different signs and result sign differs from x.
- Mult:
  - P = full 2*WIDTH-bit signed product x*y.
  - result = P[WIDTH-1+INT_SHIFT : INT_SHIFT]: arithmetic right shift by INT_SHIFT, truncation toward negative infinity, no rounding.
  - overflow = 1 iff bits P[2*WIDTH-1 : WIDTH-1+INT_SHIFT] are not all equal (the product does not fit in Q16.16).
  - Fraction bits lost to truncation never set overflow.
- Reserved op 11: result = 0, overflow = 0, out_valid still follows in_valid.
- Overflow is not sticky; it reflects only the current result.
- 0x80000000 operands are legal. The mult of 0x80000000 * 0x80000000 overflows.

Optional Feature:
- Macro FIP_SATURATE_EN.
- Defined: on overflow, result saturates to 0x7FFFFFFF if the true result is positive, or 0x80000000 if negative. Sign is taken from the operand signs: for add, sign of x; for sub, sign of x; for mult, sign of x XOR sign of y. Overflow is still asserted.
- Undefined: wrapped result as specified above.
- No effect on non-overflowing results or on latency.

Decomposition:
- Package fip_pkg:
  - WIDTH/INT_SHIFT defaults.
  - FIP_ONE constant (32'h00010000).
  - Op enum fip_op_e {FIP_ADD, FIP_SUB, FIP_MUL, FIP_RSVD}.
  - FIP_MAX/FIP_MIN saturation constants.
- One combinational sub-module, fip_32_mul_core: 64-bit signed product, shift, overflow detect.
- Add/sub, the saturation mux and the output register stay in the top.

Test Plan:
- Add 0x00010000 + 0x00010000 -> result 0x00020000, overflow 0. Add 0x7FFFFFFF + 0x00010000 -> overflow 1, result 0x8000FFFF (0x7FFFFFFF with FIP_SATURATE_EN).
- Add 0xFFFF0000 + 0xFFFFFFFF -> result 0xFFFEFFFF, overflow 0. Sub 0x00020000 - 0x00010000 -> 0x00010000, overflow 0. Sub 0x80000000 - 0x00000001 -> overflow 1, result 0x7FFFFFFF (0x80000000 saturated).
- Mult 0x00010000*0x00010000 -> 0x00010000. 0x00008000*0x00008000 -> 0x00004000. 0xFFFF8000*0x00008000 -> 0xFFFFC000. 1*1 -> 0x00000000. x*0 -> 0. All with overflow 0.
- Mult 0x40000000*0x00040000 and 0xC0000000*0xFFFC0000 -> overflow 1, result 0x00000000 (0x7FFFFFFF saturated).
- Back-to-back in_valid for 4 cycles with mixed ops -> each result exactly 1 cycle later. A bubble gives out_valid = 0 with result held. Op 11 -> result 0, overflow 0.
- Assert reset asynchronously mid-stream -> outputs 0 immediately without a clock edge. First valid after release is returned normally.
